// File: rtl/spi_pkg.sv
// Shared FSM state type and default widths for the SPI SCLK generator.
package spi_pkg;

    localparam int unsigned SPI_CNT_W_DEF  = 8;
    localparam int unsigned SPI_BITS_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period counter: counts 0..div_q while enabled, pulses tick on div_q and reloads to 0.
module spi_sclk_tick
    import spi_pkg::*;
#(
    parameter int unsigned CNT_W = SPI_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] div_q,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == div_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK generator with sample/shift strobes and transfer sequencing.
// Define SPI_SCLK_GEN_GAP_EN to add a div+1 cycle chip-select hold (GAP) before DONE.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CNT_W  = SPI_CNT_W_DEF,
    parameter int unsigned BITS_W = SPI_BITS_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  div,
    input  logic [BITS_W-1:0] nbits,
    input  logic              cpol,
    input  logic              cpha,
    output logic              sclk,
    output logic              busy,
    output logic              done,
    output logic              sample_stb,
    output logic              shift_stb
);

    localparam int unsigned TGL_W = BITS_W + 1;

    spi_state_e        r_state;
    spi_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_div_q;
    logic [BITS_W-1:0] r_nbits_q;
    logic              r_cpol_q;
    logic              r_cpha_q;
    logic [TGL_W-1:0]  r_tgl_cnt;
    logic              r_sclk;
    logic              r_busy;
    logic              r_done;
    logic              r_sample_stb;
    logic              r_shift_stb;

    logic w_tick;
    logic w_tick_en;
    logic w_tick_clr;
    logic w_fin;
    logic w_accept;
    logic w_abort;
    logic w_toggle;
    logic w_lead_sample;

    assign w_fin    = (r_tgl_cnt == {r_nbits_q, 1'b0});
    assign w_accept = (r_state == IDLE) && start && !abort;

`ifdef SPI_SCLK_GEN_GAP_EN
    assign w_abort   = abort && ((r_state == RUN) || (r_state == GAP));
    assign w_tick_en = ((r_state == RUN) && !w_fin) || (r_state == GAP);
`else
    assign w_abort   = abort && (r_state == RUN);
    assign w_tick_en = (r_state == RUN) && !w_fin;
`endif

    // Counter restarts from 0 on every phase entry and stays parked outside RUN/GAP.
    assign w_tick_clr = (r_state == IDLE) || (r_state == DONE) || (w_state_nxt != r_state);
    assign w_toggle   = w_tick && (r_state == RUN) && !abort;

    // Even toggle count means the next edge is a leading edge.
    assign w_lead_sample = ~r_tgl_cnt[0] ^ r_cpha_q;

    spi_sclk_tick #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_tick_en),
        .clear   (w_tick_clr),
        .div_q   (r_div_q),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_fin) begin
`ifdef SPI_SCLK_GEN_GAP_EN
                    w_state_nxt = GAP;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef SPI_SCLK_GEN_GAP_EN
            GAP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_state_nxt = DONE;
                end
            end
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_q      <= '0;
            r_nbits_q    <= '0;
            r_cpol_q     <= 1'b0;
            r_cpha_q     <= 1'b0;
            r_tgl_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sample_stb <= 1'b0;
            r_shift_stb  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_div_q   <= div;
                r_nbits_q <= nbits;
                r_cpol_q  <= cpol;
                r_cpha_q  <= cpha;
            end

            if (r_state == IDLE) begin
                r_tgl_cnt <= '0;
            end else if (w_toggle) begin
                r_tgl_cnt <= r_tgl_cnt + TGL_W'(1);
            end

            if (w_accept) begin
                r_sclk <= cpol;
            end else if (w_abort) begin
                r_sclk <= r_cpol_q;
            end else if (w_toggle) begin
                r_sclk <= ~r_sclk;
            end

            r_sample_stb <= w_toggle && w_lead_sample;
            r_shift_stb  <= w_toggle && !w_lead_sample;
            r_busy       <= (w_state_nxt == RUN) || (w_state_nxt == GAP);
            r_done       <= (w_state_nxt == DONE);
        end
    end

    assign sclk       = r_sclk;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_stb = r_sample_stb;
    assign shift_stb  = r_shift_stb;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: waveform timing, strobes, abort, async reset, nbits=0.
module tb_spi_sclk_gen;

`ifdef SPI_SCLK_GEN_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] div;
    logic [4:0] nbits;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       busy;
    logic       done;
    logic       sample_stb;
    logic       shift_stb;

    int n_checks = 0;
    int n_fail   = 0;

    int   n_tog, first_k, bad_spacing, bad_stb, n_sample, n_shift;
    int   done_k, n_done, bad_busy, abort_k;
    logic sclk0, busy0, end_sclk, end_busy, ab_busy, ab_sclk;

    spi_sclk_gen #(
        .CNT_W  (8),
        .BITS_W (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .div        (div),
        .nbits      (nbits),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk       (sclk),
        .busy       (busy),
        .done       (done),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_done(input int d, input int nb);
        return 2 * nb * (d + 1) + 1 + GAP_EN * (d + 1);
    endfunction

    // mode 1: disturb inputs mid-transfer and pulse start while busy and in DONE.
    // abort_at > 0: raise abort right after that many toggles have been seen.
    task automatic run_xfer(input logic [7:0] d, input logic [4:0] nb, input logic cp,
                            input logic ch, input int mode, input int abort_at);
        logic prev;
        logic exp_samp;
        logic sample_on_rise;
        bit   ab_issued;
        n_tog = 0; first_k = -1; bad_spacing = 0; bad_stb = 0; n_sample = 0; n_shift = 0;
        done_k = -1; n_done = 0; bad_busy = 0; abort_k = -1; ab_issued = 0;
        ab_busy = 1'bx; ab_sclk = 1'bx;
        sample_on_rise = (cp == ch);
        div = d; nbits = nb; cpol = cp; cpha = ch; start = 1'b1;
        step();
        start = 1'b0;
        sclk0 = sclk; busy0 = busy; prev = sclk;
        for (int kk = 1; kk <= 600; kk++) begin
            step();
            if (kk == abort_k) begin
                ab_busy = busy; ab_sclk = sclk; abort = 1'b0;
                if (sample_stb !== 1'b0 || shift_stb !== 1'b0) bad_stb++;
            end else if (sclk !== prev) begin
                n_tog++;
                if (first_k < 0) first_k = kk;
                if (kk % (int'(d) + 1) != 0) bad_spacing++;
                exp_samp = (sclk == sample_on_rise);
                if (sample_stb !== exp_samp || shift_stb !== !exp_samp) bad_stb++;
            end else if (sample_stb !== 1'b0 || shift_stb !== 1'b0) begin
                bad_stb++;
            end
            n_sample += int'(sample_stb);
            n_shift  += int'(shift_stb);
            if (done === 1'b1) begin
                n_done++;
                if (done_k < 0) done_k = kk;
                if (busy !== 1'b0) bad_busy++;
            end
            if (mode == 1) begin
                if (kk == 10) begin div = 8'd0; cpol = ~cp; cpha = ~ch; nbits = 5'd1; end
                if (kk == 20) start = 1'b1;
                if (kk == 21) start = 1'b0;
                if (done_k == kk) start = 1'b1;
                if (done_k >= 0 && kk == done_k + 1) start = 1'b0;
            end
            if (abort_at > 0 && !ab_issued && n_tog == abort_at) begin
                abort = 1'b1; ab_issued = 1; abort_k = kk + 1;
            end
            prev = sclk;
            if (done_k >= 0 && kk == done_k + 2) break;
            if (abort_k >= 0 && kk == abort_k + 30) break;
        end
        end_sclk = sclk; end_busy = busy;
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        div = '0; nbits = '0; cpol = 1'b0; cpha = 1'b0;
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample", sample_stb, 0);
        chk("rst_shift", shift_stb, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        chk("idle_sclk", sclk, 0);
        chk("idle_busy", busy, 0);

        // div=3 nbits=8 mode0, with mid-transfer input changes and stray starts
        run_xfer(8'd3, 5'd8, 1'b0, 1'b0, 1, 0);
        chk("m0_busy_at_start", busy0, 1);
        chk("m0_sclk_at_start", sclk0, 0);
        chk("m0_first_rise", first_k, 4);
        chk("m0_toggles", n_tog, 16);
        chk("m0_spacing", bad_spacing, 0);
        chk("m0_strobe_map", bad_stb, 0);
        chk("m0_samples", n_sample, 8);
        chk("m0_shifts", n_shift, 8);
        chk("m0_done_cycle", done_k, exp_done(3, 8));
        chk("m0_done_pulses", n_done, 1);
        chk("m0_busy_with_done", bad_busy, 0);
        chk("m0_end_sclk", end_sclk, 0);
        chk("m0_idle_after_done_start", end_busy, 0);

        // div=0 nbits=4 mode3
        run_xfer(8'd0, 5'd4, 1'b1, 1'b1, 0, 0);
        chk("m3_sclk_at_start", sclk0, 1);
        chk("m3_first_toggle", first_k, 1);
        chk("m3_toggles", n_tog, 8);
        chk("m3_strobe_map", bad_stb, 0);
        chk("m3_samples", n_sample, 4);
        chk("m3_shifts", n_shift, 4);
        chk("m3_done_cycle", done_k, exp_done(0, 4));
        chk("m3_end_sclk", end_sclk, 1);

        // abort one cycle after the 3rd toggle
        run_xfer(8'd2, 5'd8, 1'b0, 1'b0, 0, 3);
        chk("ab_sclk_at_start", sclk0, 0);
        chk("ab_busy_next", ab_busy, 0);
        chk("ab_sclk_next", ab_sclk, 0);
        chk("ab_toggles", n_tog, 3);
        chk("ab_spacing", bad_spacing, 0);
        chk("ab_strobes", bad_stb, 0);
        chk("ab_samples", n_sample, 2);
        chk("ab_shifts", n_shift, 1);
        chk("ab_no_done", n_done, 0);
        chk("ab_end_busy", end_busy, 0);

        // asynchronous reset between clock edges mid-transfer
        div = 8'd1; nbits = 5'd8; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_sclk", sclk, 1);
        chk("pre_rst_sample", sample_stb, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_sclk", sclk, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_sample", sample_stb, 0);
        chk("async_rst_shift", shift_stb, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        // normal transfer after reset, mode1
        run_xfer(8'd0, 5'd2, 1'b0, 1'b1, 0, 0);
        chk("m1_toggles", n_tog, 4);
        chk("m1_strobe_map", bad_stb, 0);
        chk("m1_samples", n_sample, 2);
        chk("m1_shifts", n_shift, 2);
        chk("m1_done_cycle", done_k, exp_done(0, 2));
        chk("m1_end_sclk", end_sclk, 0);

        // nbits=0: no toggles, no strobes, done right away
        run_xfer(8'd5, 5'd0, 1'b1, 1'b0, 0, 0);
        chk("nb0_busy_at_start", busy0, 1);
        chk("nb0_sclk_at_start", sclk0, 1);
        chk("nb0_toggles", n_tog, 0);
        chk("nb0_strobes", n_sample + n_shift, 0);
        chk("nb0_done_cycle", done_k, exp_done(5, 0));
        chk("nb0_done_pulses", n_done, 1);
        chk("nb0_end_sclk", end_sclk, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
